// File: rtl/sc_spi_tgt.sv
// SPI target protocol engine: oversamples CSB/SCLK/MOSI on SPICLK, receives 1..32-bit
// frames into RXDATA and shifts TXDATA out on MISO, with back-to-back frame support.
module sc_spi_tgt #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        SPICLK,
    input  logic        SYSRST,
    input  logic        ENABLE,
    input  logic [4:0]  DWIDTH,
    input  logic        CPOL,
    input  logic        CPHA,
    input  logic        BORDER,
    input  logic [31:0] TXDATA,
    output logic        TXLOAD,
    output logic [31:0] RXDATA,
    output logic        RXVALID,
    output logic        FRMERR,
    output logic        SPIBUSY,
    input  logic        CSB,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISOOE
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BC_W   = 5;

    typedef enum logic {IDLE, FRAME} state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                csb_prev_q, sclk_prev_q;
    logic [BC_W-1:0]     bc_q, bc_d;
    logic [DATA_W-1:0]   txsr_q, txsr_d;
    logic [DATA_W-1:0]   rxsr_q, rxsr_d;
    logic [DATA_W-1:0]   rxdata_q, rxdata_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d, border_q, border_d;
    logic [BC_W-1:0]     dw_q, dw_d;
    logic                rxvalid_q, rxvalid_d, txload_q, txload_d, frmerr_q, frmerr_d;
    logic                miso_q, miso_d, misooe_q, misooe_d, spibusy_q, spibusy_d;

    logic csb_s, sclk_s, mosi_s;
    logic csb_fall, csb_rise, sclk_rise, sclk_fall;
    logic lead_edge, trail_edge, sample_edge, drive_edge;
    logic border_eff;

    // Bit position within the word for the n-th bit on the wire.
    function automatic logic [BC_W-1:0] bit_idx(input logic [BC_W-1:0] n,
                                                 input logic [BC_W-1:0] dw,
                                                 input logic            border);
        if (border) begin
            return {n[4:3], ~n[2:0]};
        end
        return dw - n;
    endfunction

    always_comb begin
        csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], CSB};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    end

    assign csb_s       = csb_sync_q[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign csb_fall    = csb_prev_q & ~csb_s;
    assign csb_rise    = ~csb_prev_q & csb_s;
    assign sclk_rise   = ~sclk_prev_q & sclk_s;
    assign sclk_fall   = sclk_prev_q & ~sclk_s;
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge : trail_edge;
    // Byte-swapped order only makes sense for whole-byte frames.
    assign border_eff  = BORDER & (DWIDTH[2:0] == 3'b111);

    always_comb begin
        state_d   = state_q;
        bc_d      = bc_q;
        txsr_d    = txsr_q;
        rxsr_d    = rxsr_q;
        rxdata_d  = rxdata_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        dw_d      = dw_q;
        border_d  = border_q;
        rxvalid_d = 1'b0;
        txload_d  = 1'b0;
        frmerr_d  = 1'b0;
        miso_d    = miso_q;
        misooe_d  = misooe_q;
        case (state_q)
            IDLE: begin
                if (csb_fall && ENABLE) begin
                    cpol_d   = CPOL;
                    cpha_d   = CPHA;
                    dw_d     = DWIDTH;
                    border_d = border_eff;
                    txsr_d   = TXDATA;
                    txload_d = 1'b1;
                    rxsr_d   = '0;
                    bc_d     = '0;
                    misooe_d = 1'b1;
                    state_d  = FRAME;
                    if (!CPHA) begin
                        miso_d = TXDATA[bit_idx(5'd0, DWIDTH, border_eff)];
                    end
                end
            end
            FRAME: begin
                if (sample_edge) begin
                    rxsr_d[bit_idx(bc_q, dw_q, border_q)] = mosi_s;
                    if (bc_q == dw_q) begin
                        rxdata_d  = rxsr_d;
                        rxvalid_d = 1'b1;
                        rxsr_d    = '0;
                        bc_d      = '0;
                        txsr_d    = TXDATA;
                        txload_d  = 1'b1;
                        if (!cpha_q) begin
                            miso_d = TXDATA[bit_idx(5'd0, dw_q, border_q)];
                        end
                    end else begin
                        bc_d = bc_q + 5'd1;
                    end
                end else if (drive_edge) begin
                    miso_d = txsr_q[bit_idx(bc_q, dw_q, border_q)];
                end
                // Sample above is processed before the deselect check.
                if (csb_rise) begin
                    state_d  = IDLE;
                    misooe_d = 1'b0;
                    miso_d   = 1'b0;
                    frmerr_d = (bc_d != 5'd0);
                end
            end
        endcase
        spibusy_d = (state_d == FRAME);
    end

    always_ff @(posedge SPICLK) begin
        if (SYSRST) begin
            state_q     <= IDLE;
            csb_sync_q  <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csb_prev_q  <= 1'b0;
            sclk_prev_q <= 1'b0;
            bc_q        <= '0;
            txsr_q      <= '0;
            rxsr_q      <= '0;
            rxdata_q    <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            dw_q        <= '0;
            border_q    <= 1'b0;
            rxvalid_q   <= 1'b0;
            txload_q    <= 1'b0;
            frmerr_q    <= 1'b0;
            miso_q      <= 1'b0;
            misooe_q    <= 1'b0;
            spibusy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            csb_sync_q  <= csb_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            csb_prev_q  <= csb_s;
            sclk_prev_q <= sclk_s;
            bc_q        <= bc_d;
            txsr_q      <= txsr_d;
            rxsr_q      <= rxsr_d;
            rxdata_q    <= rxdata_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            dw_q        <= dw_d;
            border_q    <= border_d;
            rxvalid_q   <= rxvalid_d;
            txload_q    <= txload_d;
            frmerr_q    <= frmerr_d;
            miso_q      <= miso_d;
            misooe_q    <= misooe_d;
            spibusy_q   <= spibusy_d;
        end
    end

    assign TXLOAD  = txload_q;
    assign RXDATA  = rxdata_q;
    assign RXVALID = rxvalid_q;
    assign FRMERR  = frmerr_q;
    assign SPIBUSY = spibusy_q;
    assign MISO    = miso_q;
    assign MISOOE  = misooe_q;

endmodule

// File: tb/tb_sc_spi_tgt.sv
// Directed self-checking bench for sc_spi_tgt: a bit-banged SPI master drives all four
// modes, byte-order, back-to-back frames, aborted frames, disabled select and reset.
module tb_sc_spi_tgt;

    localparam int H = 8;

    logic        SPICLK = 1'b0;
    logic        SYSRST = 1'b1;
    logic        ENABLE = 1'b1;
    logic [4:0]  DWIDTH = 5'd7;
    logic        CPOL   = 1'b0;
    logic        CPHA   = 1'b0;
    logic        BORDER = 1'b0;
    logic [31:0] TXDATA = 32'h0;
    logic        TXLOAD;
    logic [31:0] RXDATA;
    logic        RXVALID;
    logic        FRMERR;
    logic        SPIBUSY;
    logic        CSB    = 1'b1;
    logic        SCLK   = 1'b0;
    logic        MOSI   = 1'b0;
    logic        MISO;
    logic        MISOOE;

    int n_cmp = 0;
    int n_bad = 0;
    int rxv_cnt = 0;
    int txl_cnt = 0;
    int ferr_cnt = 0;
    logic [31:0] rx_log [0:15];
    logic oe_seen = 1'b0;

    sc_spi_tgt #(.SYNC_STAGES(2)) dut (
        .SPICLK(SPICLK), .SYSRST(SYSRST), .ENABLE(ENABLE), .DWIDTH(DWIDTH),
        .CPOL(CPOL), .CPHA(CPHA), .BORDER(BORDER), .TXDATA(TXDATA),
        .TXLOAD(TXLOAD), .RXDATA(RXDATA), .RXVALID(RXVALID), .FRMERR(FRMERR),
        .SPIBUSY(SPIBUSY), .CSB(CSB), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .MISOOE(MISOOE)
    );

    always #5 SPICLK = ~SPICLK;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge SPICLK) begin
        if (RXVALID === 1'b1) begin
            if (rxv_cnt < 16) rx_log[rxv_cnt] = RXDATA;
            rxv_cnt++;
        end
        if (TXLOAD === 1'b1) txl_cnt++;
        if (FRMERR === 1'b1) ferr_cnt++;
        if (MISOOE === 1'b1) oe_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge SPICLK);
    endtask

    // Master shifts bits in time order (seq[nbits-1] first) and records MISO likewise.
    task automatic spi_bits(input logic [63:0] mosi_seq, input int nbits,
                            output logic [63:0] miso_seq);
        miso_seq = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!CPHA) begin
                MOSI = mosi_seq[nbits-1-i];
                wait_clk(H);
                SCLK = ~CPOL;
                miso_seq[nbits-1-i] = MISO;
                wait_clk(H);
                SCLK = CPOL;
            end else begin
                SCLK = ~CPOL;
                MOSI = mosi_seq[nbits-1-i];
                wait_clk(H);
                SCLK = CPOL;
                miso_seq[nbits-1-i] = MISO;
                wait_clk(H);
            end
        end
        wait_clk(H);
    endtask

    task automatic frame_begin();
        SCLK = CPOL;
        wait_clk(8);
        CSB = 1'b0;
        wait_clk(8);
    endtask

    task automatic frame_end();
        CSB = 1'b1;
        wait_clk(8);
    endtask

    task automatic test_reset();
        SYSRST = 1'b1;
        wait_clk(3);
        n_cmp++; if (MISO !== 1'b0) begin n_bad++; $display("FAIL reset_miso got %b want 0", MISO); end
        n_cmp++; if (MISOOE !== 1'b0) begin n_bad++; $display("FAIL reset_misooe got %b want 0", MISOOE); end
        n_cmp++; if (RXDATA !== 32'h0) begin n_bad++; $display("FAIL reset_rxdata got %h want 0", RXDATA); end
        n_cmp++; if ({RXVALID, TXLOAD, FRMERR} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {RXVALID, TXLOAD, FRMERR}); end
        n_cmp++; if (SPIBUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", SPIBUSY); end
        SYSRST = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_mode0();
        logic [63:0] m;
        int rxb, txb, feb;
        CPOL = 1'b0; CPHA = 1'b0; DWIDTH = 5'd7; BORDER = 1'b0; TXDATA = 32'h0000_003C;
        rxb = rxv_cnt; txb = txl_cnt; feb = ferr_cnt;
        frame_begin();
        n_cmp++; if (txl_cnt - txb !== 1) begin n_bad++; $display("FAIL m0_txload_start got %0d want 1", txl_cnt - txb); end
        n_cmp++; if ({SPIBUSY, MISOOE} !== 2'b11) begin n_bad++; $display("FAIL m0_busy_oe got %b want 11", {SPIBUSY, MISOOE}); end
        spi_bits(64'hA5, 8, m);
        frame_end();
        n_cmp++; if (m[7:0] !== 8'h3C) begin n_bad++; $display("FAIL m0_miso got %h want 3c", m[7:0]); end
        n_cmp++; if (RXDATA !== 32'h0000_00A5) begin n_bad++; $display("FAIL m0_rxdata got %h want 000000a5", RXDATA); end
        n_cmp++; if (rxv_cnt - rxb !== 1) begin n_bad++; $display("FAIL m0_rxvalid got %0d want 1", rxv_cnt - rxb); end
        n_cmp++; if (ferr_cnt - feb !== 0) begin n_bad++; $display("FAIL m0_frmerr got %0d want 0", ferr_cnt - feb); end
        n_cmp++; if ({SPIBUSY, MISOOE} !== 2'b00) begin n_bad++; $display("FAIL m0_idle got %b want 00", {SPIBUSY, MISOOE}); end
    endtask

    task automatic test_mode3_border();
        logic [63:0] m;
        int rxb;
        CPOL = 1'b1; CPHA = 1'b1; DWIDTH = 5'd31; BORDER = 1'b1; TXDATA = 32'hDDCC_BBAA;
        rxb = rxv_cnt;
        frame_begin();
        spi_bits(64'h7856_3412, 32, m);
        frame_end();
        n_cmp++; if (m[31:0] !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL m3_miso got %h want aabbccdd", m[31:0]); end
        n_cmp++; if (RXDATA !== 32'h1234_5678) begin n_bad++; $display("FAIL m3_rxdata got %h want 12345678", RXDATA); end
        n_cmp++; if (rxv_cnt - rxb !== 1) begin n_bad++; $display("FAIL m3_rxvalid got %0d want 1", rxv_cnt - rxb); end
    endtask

    task automatic test_back_to_back(input logic cpol, input logic cpha,
                                     input logic [31:0] tx0, input logic [31:0] tx1,
                                     input logic [15:0] rx0, input logic [15:0] rx1,
                                     input logic [31:0] exp_miso);
        logic [63:0] m;
        int rxb, txb, feb;
        CPOL = cpol; CPHA = cpha; DWIDTH = 5'd15; BORDER = 1'b0; TXDATA = tx0;
        rxb = rxv_cnt; txb = txl_cnt; feb = ferr_cnt;
        frame_begin();
        TXDATA = tx1;
        n_cmp++; if (txl_cnt - txb !== 1) begin n_bad++; $display("FAIL b2b_txload_start got %0d want 1", txl_cnt - txb); end
        spi_bits(64'({rx0, rx1}), 32, m);
        n_cmp++; if (m[31:0] !== exp_miso) begin n_bad++; $display("FAIL b2b_miso got %h want %h", m[31:0], exp_miso); end
        n_cmp++; if (rxv_cnt - rxb !== 2) begin n_bad++; $display("FAIL b2b_rxvalid got %0d want 2", rxv_cnt - rxb); end
        n_cmp++; if (rx_log[rxb] !== {16'h0, rx0}) begin n_bad++; $display("FAIL b2b_word0 got %h want %h", rx_log[rxb], {16'h0, rx0}); end
        n_cmp++; if (rx_log[rxb+1] !== {16'h0, rx1}) begin n_bad++; $display("FAIL b2b_word1 got %h want %h", rx_log[rxb+1], {16'h0, rx1}); end
        n_cmp++; if (txl_cnt - txb !== 3) begin n_bad++; $display("FAIL b2b_txload_total got %0d want 3", txl_cnt - txb); end
        frame_end();
        n_cmp++; if (ferr_cnt - feb !== 0) begin n_bad++; $display("FAIL b2b_frmerr got %0d want 0", ferr_cnt - feb); end
    endtask

    task automatic test_frame_error();
        logic [63:0] m;
        int rxb, feb;
        CPOL = 1'b0; CPHA = 1'b0; DWIDTH = 5'd7; BORDER = 1'b0; TXDATA = 32'h0000_00FF;
        rxb = rxv_cnt; feb = ferr_cnt;
        frame_begin();
        spi_bits(64'h16, 5, m);
        CSB = 1'b1;
        wait_clk(4);
        n_cmp++; if ({MISOOE, MISO} !== 2'b00) begin n_bad++; $display("FAIL ferr_oe_miso got %b want 00", {MISOOE, MISO}); end
        wait_clk(8);
        n_cmp++; if (ferr_cnt - feb !== 1) begin n_bad++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - feb); end
        n_cmp++; if (rxv_cnt - rxb !== 0) begin n_bad++; $display("FAIL ferr_rxvalid got %0d want 0", rxv_cnt - rxb); end
        n_cmp++; if (RXDATA !== 32'h0000_7FFE) begin n_bad++; $display("FAIL ferr_rxdata got %h want 00007ffe", RXDATA); end
        n_cmp++; if (SPIBUSY !== 1'b0) begin n_bad++; $display("FAIL ferr_busy got %b want 0", SPIBUSY); end
    endtask

    task automatic test_enable_off();
        logic [63:0] m;
        int rxb, txb;
        ENABLE = 1'b0;
        CPOL = 1'b0; CPHA = 1'b0; DWIDTH = 5'd7; TXDATA = 32'h0000_0055;
        rxb = rxv_cnt; txb = txl_cnt;
        wait_clk(1);
        oe_seen = 1'b0;
        frame_begin();
        spi_bits(64'hC3, 8, m);
        frame_end();
        n_cmp++; if (txl_cnt - txb !== 0) begin n_bad++; $display("FAIL dis_txload got %0d want 0", txl_cnt - txb); end
        n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL dis_misooe got %b want 0", oe_seen); end
        n_cmp++; if (rxv_cnt - rxb !== 0) begin n_bad++; $display("FAIL dis_rxvalid got %0d want 0", rxv_cnt - rxb); end
        ENABLE = 1'b1;
    endtask

    task automatic test_reset_midframe();
        logic [63:0] m;
        int rxb, txb;
        CPOL = 1'b0; CPHA = 1'b0; DWIDTH = 5'd7; BORDER = 1'b0; TXDATA = 32'h0000_0081;
        frame_begin();
        spi_bits(64'h5, 3, m);
        SYSRST = 1'b1;
        wait_clk(1);
        SYSRST = 1'b0;
        wait_clk(1);
        n_cmp++; if ({MISOOE, SPIBUSY, MISO} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_outs got %b want 000", {MISOOE, SPIBUSY, MISO}); end
        n_cmp++; if (RXDATA !== 32'h0) begin n_bad++; $display("FAIL rst_mid_rxdata got %h want 0", RXDATA); end
        rxb = rxv_cnt; txb = txl_cnt;
        spi_bits(64'hFF, 8, m);
        n_cmp++; if ((rxv_cnt - rxb) + (txl_cnt - txb) !== 0) begin n_bad++; $display("FAIL rst_mid_noframe got %0d want 0", (rxv_cnt - rxb) + (txl_cnt - txb)); end
        frame_end();
        rxb = rxv_cnt;
        frame_begin();
        spi_bits(64'h5A, 8, m);
        frame_end();
        n_cmp++; if (RXDATA !== 32'h0000_005A) begin n_bad++; $display("FAIL rst_mid_rxdata2 got %h want 0000005a", RXDATA); end
        n_cmp++; if (rxv_cnt - rxb !== 1) begin n_bad++; $display("FAIL rst_mid_rxvalid got %0d want 1", rxv_cnt - rxb); end
        n_cmp++; if (m[7:0] !== 8'h81) begin n_bad++; $display("FAIL rst_mid_miso got %h want 81", m[7:0]); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3_border();
        test_back_to_back(1'b0, 1'b1, 32'hFFFF_C0DE, 32'h1234_5A5A,
                          16'h1234, 16'hBEEF, 32'hC0DE_5A5A);
        test_back_to_back(1'b1, 1'b0, 32'hAAAA_0F0F, 32'h0000_F00F,
                          16'h8001, 16'h7FFE, 32'h0F0F_F00F);
        test_frame_error();
        test_enable_off();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sc_spi_tgt.md
# sc_spi_tgt

SPI target (slave) protocol engine: the responding end of the SPI link driven by the SPI protocol controller. It oversamples CSB/SCLK/MOSI on the system-side clock and receives frames of 1–32 bits into a parallel word. It shifts a parallel transmit word out on MISO. It sits between the external SPI pins and the register/FIFO layer of a target-mode SPI core.

## Interface
Parameters
- SYNC_STAGES, 2: synchronizer depth for CSB, SCLK and MOSI (minimum 2).

Ports
- SPICLK  in  1  engine clock; SPICLK frequency ≥ 8× SCLK frequency.
- SYSRST  in  1  reset; one clock; reset is synchronous and active-high.
- ENABLE  in  1  1 = respond to CSB assertion; checked only at CSB falling edge.
- DWIDTH  in  5  frame length minus 1 (0..31 → 1..32 bits).
- CPOL  in  1  SCLK idle level.
- CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- BORDER  in  1  0 = MSB-first word; 1 = byte order LSB-byte-first, MSB-first within byte.
- TXDATA  in  32  word to transmit; captured at frame start.
- TXLOAD  out  1  one-cycle pulse: TXDATA captured this cycle; present next word before next frame start.
- RXDATA  out  32  last complete received word; unused upper bits 0.
- RXVALID  out  1  one-cycle pulse: RXDATA updated.
- FRMERR  out  1  one-cycle pulse: CSB deasserted mid-frame.
- SPIBUSY  out  1  1 while in FRAME state.
- CSB  in  1  chip select, active low, asynchronous to SPICLK.
- SCLK  in  1  SPI clock, asynchronous.
- MOSI  in  1  SPI data in.
- MISO  out  1  SPI data out (registered).
- MISOOE  out  1  MISO output enable (1 while selected).

## Operation
- Synchronizers: CSB, SCLK, MOSI each pass SYNC_STAGES flops, plus one "previous" flop for edge detection. All CSB synchronizer and previous flops reset to 0, so a falling edge requires an observed high first. SCLK flops reset to 0.
- Edges: leading = idle→active SCLK transition per latched CPOL; trailing = reverse. The sample edge is leading if CPHA=0, trailing if CPHA=1. The drive edge is the other one.
- Bit index for bit n (0..DW): BORDER=0 → DW−n. BORDER=1 → {n[4:3],3'b000}+(7−n[2:0]). BORDER=1 is honoured only if DW[2:0]==7; otherwise it is treated as 0.
- States: IDLE, FRAME. Internal: bc[4:0] bit counter, txsr[31:0], rxsr[31:0], latched mode (cpol, cpha, DW, border).
- IDLE, CSB fall with ENABLE=1:
  - latch mode inputs; txsr←TXDATA; TXLOAD=1; rxsr←0; bc←0.
  - MISOOE←1; →FRAME.
  - If CPHA=0, MISO←TXDATA[idx(0)].
- IDLE, CSB fall with ENABLE=0: stay IDLE; SCLK ignored until the next fall.
- FRAME, sample edge: rxsr[idx(bc)]←MOSI_sync.
  - If bc==DW: RXDATA←rxsr with that bit merged; RXVALID=1; bc←0; txsr←TXDATA; TXLOAD=1. If CPHA=0, MISO←TXDATA[idx(0)].
  - Else: bc←bc+1.
- FRAME, drive edge: MISO←txsr[idx(bc)]. For CPHA=0 this uses the incremented bc. For CPHA=1 it uses the current bc.
- FRAME, CSB rise: →IDLE; MISOOE←0; MISO←0. FRMERR=1 if bc≠0 after this cycle's sample update. A partial frame is discarded and RXDATA is unchanged.
- Back-to-back frames: while CSB stays low, frames repeat with no gap bits. TXDATA is captured at each frame boundary.
- Mode inputs and ENABLE changed mid-frame have no effect until the next CSB fall.

## Timing
- Reset values: MISO=0, MISOOE=0, RXDATA=0, RXVALID=0, TXLOAD=0, FRMERR=0, SPIBUSY=0; state IDLE.
- Reset mid-frame: state goes to IDLE. CSB held low after reset starts no frame; a high→low transition is required.
- Pin-to-detect latency: SYNC_STAGES+1 SPICLK cycles from pin change to edge action.
- MISO updates 1 cycle after the detected drive edge, i.e. SYNC_STAGES+2 cycles after the SCLK pin edge.
- RXVALID pulses 1 cycle after the last sample edge is detected. TXLOAD pulses in the same cycle as the capture.
- SPIBUSY rises 1 cycle after CSB fall detection and falls 1 cycle after CSB rise detection.
- Simultaneous sample edge and CSB rise: the sample is processed first. A completing frame gives RXVALID=1 and FRMERR=0.
- SCLK edges while in IDLE, and an SCLK level change coincident with CSB fall detection, are ignored.

## Test plan
- Mode 0, DWIDTH=7, BORDER=0: master sends 0xA5 with TXDATA=0x3C → MISO bit sequence 0,0,1,1,1,1,0,0; RXDATA=0x000000A5; one RXVALID; one TXLOAD.
- Mode 3, DWIDTH=31, BORDER=1: master sends bytes 0x78,0x56,0x34,0x12 → RXDATA=0x12345678; MISO carries TXDATA=0xDDCCBBAA as bytes AA,BB,CC,DD.
- Modes 1 and 2, DWIDTH=15, two frames in one CSB low → two RXVALID pulses with correct words; second TXLOAD at the frame boundary; second TXDATA word shifted out.
- CSB rises after 5 of 8 bits → FRMERR pulse, no RXVALID, RXDATA retains its previous value, MISOOE=0 within SYNC_STAGES+2 cycles.
- ENABLE=0 at CSB fall → no TXLOAD, MISOOE stays 0 for the whole frame.
- SYSRST asserted mid-frame with CSB held low → all outputs 0, no frame until CSB toggles high then low; a new 0x5A frame is then received correctly.
